// File: rtl/divider_pkg.sv
// Shared types for the RV32M unsigned divide unit: the machine word and the
// divider's control states.
package divider_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] rv32i_word;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage : divider_pkg

// File: rtl/divider_if.sv
// Request/response bundle between the execute stage (master) and the divider
// (slave). A request is a one-cycle start with operands; the response is a
// one-cycle div_valid with quotient/remain held until the next result.
import divider_pkg::*;

interface divider_if;

  logic      start;
  rv32i_word a;
  rv32i_word b;
  rv32i_word quotient;
  rv32i_word remain;
  logic      div_valid;

  modport master (
    output start, a, b,
    input  quotient, remain, div_valid
  );

  modport slave (
    input  start, a, b,
    output quotient, remain, div_valid
  );

endinterface : divider_if

// File: rtl/divider_step.sv
// One radix-2 restoring iteration: shift {rem,quo} left by one, try to
// subtract the divisor and keep the difference only if it did not go negative.
module divider_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  // The partial remainder is always below the divisor, so the shifted value is
  // below 2*divisor and a WIDTH+1 bit difference has an unambiguous sign bit.
  logic [WIDTH:0] rem_shifted;
  logic [WIDTH:0] trial;

  assign rem_shifted = {rem_i, quo_i[WIDTH-1]};
  assign trial       = rem_shifted - {1'b0, divisor_i};

  // Restore or commit the trial subtraction and shift in the quotient bit.
  // NOTE: every output of a combinational block is assigned on every path
  // (defaults first, or a full if/else as here); a path that leaves one
  // unassigned makes synthesis infer a latch.
  always_comb begin
    if (!trial[WIDTH]) begin
      rem_o = trial[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = rem_shifted[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule : divider_step

// File: rtl/divider.sv
// Iterative unsigned divider for RV32M DIVU/REMU. One quotient bit per clock;
// a result appears 33 cycles after an accepted start (1 cycle for b == 0,
// which returns all-ones / dividend as RISC-V requires).
import divider_pkg::*;

module divider #(
  parameter int unsigned WIDTH = XLEN
) (
  input  logic      clk,
  input  logic      rst,
  divider_if.slave  bus
);

  localparam int unsigned           CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]      LAST_ITER = CNT_W'(WIDTH - 1);

  div_state_t       state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;          // partial remainder accumulator
  logic [WIDTH-1:0] quo_q, quo_d;          // dividend in, quotient out
  logic [WIDTH-1:0] divisor_q, divisor_d;  // operand b held for the whole op
  logic [CNT_W-1:0] cnt_q, cnt_d;          // iterations already performed
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remain_q, remain_d;
  logic             valid_q, valid_d;

  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;

  divider_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (divisor_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  // Next-state and datapath control. Results are written only on entry to
  // DONE so the outputs stay stable across the following IDLE/BUSY cycles.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    divisor_d  = divisor_q;
    cnt_d      = cnt_q;
    quotient_d = quotient_q;
    remain_d   = remain_q;
    valid_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          divisor_d = bus.b;
          if (bus.b != '0) begin
            rem_d   = '0;
            quo_d   = bus.a;
            cnt_d   = '0;
            state_d = BUSY;
          end else begin
            quotient_d = '1;
            remain_d   = bus.a;
            valid_d    = 1'b1;
            state_d    = DONE;
          end
        end
      end

      BUSY: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          quotient_d = step_quo;
          remain_d   = step_rem;
          valid_d    = 1'b1;
          state_d    = DONE;
        end
      end

      // Any start seen here is dropped; only IDLE accepts requests.
      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  // NOTE: sequential state uses non-blocking (<=) assignments so every
  // register samples its pre-edge value regardless of statement order.
  // NOTE: there is no memory array here, so every register is cleared on
  // reset; a reset mid-operation therefore drops the result silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      quo_q      <= '0;
      divisor_q  <= '0;
      cnt_q      <= '0;
      quotient_q <= '0;
      remain_q   <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      divisor_q  <= divisor_d;
      cnt_q      <= cnt_d;
      quotient_q <= quotient_d;
      remain_q   <= remain_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.quotient  = quotient_q;
  assign bus.remain    = remain_q;
  assign bus.div_valid = valid_q;

endmodule : divider

// File: tb/tb_divider.sv
// Self-checking bench for the divider: directed vector table, multi-cycle
// corner sequences (start while busy/done, reset mid-operation) and random
// operands against an arithmetic reference model.
import divider_pkg::*;

module tb_divider;

  typedef struct {
    rv32i_word a;
    rv32i_word b;
    rv32i_word q;
    rv32i_word r;
    int        lat;
  } vec_t;

  localparam int TIMEOUT = 100;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic prev_valid;

  divider_if dif ();

  divider dut (
    .clk (clk),
    .rst (rst),
    .bus (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // div_valid must never be high on two consecutive cycles.
  always @(negedge clk) begin
    if (dif.div_valid === 1'b1) begin
      n_checks++;
      if (prev_valid === 1'b1) begin
        n_fail++;
        $display("FAIL valid_width: div_valid high for 2+ cycles at %0t", $time);
      end
    end
    prev_valid = dif.div_valid;
  end

  // Issue one request and wait for div_valid. lat counts falling edges after
  // the start edge up to and including the one where div_valid is seen.
  // Operands are scrambled right after the start edge.
  task automatic run_op(input rv32i_word a, input rv32i_word b,
                        output rv32i_word q, output rv32i_word r, output int lat);
    @(negedge clk);
    dif.a     = a;
    dif.b     = b;
    dif.start = 1'b1;
    @(negedge clk);
    dif.start = 1'b0;
    dif.a     = $urandom;
    dif.b     = $urandom;
    lat = 1;
    while (dif.div_valid !== 1'b1 && lat < TIMEOUT) begin
      @(negedge clk);
      lat++;
    end
    q = dif.quotient;
    r = dif.remain;
  endtask

  // Reference model: plain integer division with RISC-V divide-by-zero rules.
  task automatic do_check(input string tag, input rv32i_word a, input rv32i_word b);
    rv32i_word q, r, eq, er;
    int lat, elat;
    eq   = (b == 0) ? 32'hFFFF_FFFF : a / b;
    er   = (b == 0) ? a : a % b;
    elat = (b == 0) ? 1 : 33;
    run_op(a, b, q, r, lat);
    check({tag, "_lat"}, 32'(lat), 32'(elat));
    check({tag, "_q"}, q, eq);
    check({tag, "_r"}, r, er);
  endtask

  // Watch for any div_valid over a window; returns 1 if one was seen.
  task automatic watch_valid(input int cycles, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (dif.div_valid === 1'b1) seen = 1'b1;
    end
  endtask

  vec_t vecs[8];

  initial begin
    rv32i_word q, r, a, b;
    int   lat;
    logic seen;

    n_checks   = 0;
    n_fail     = 0;
    prev_valid = 1'b0;

    vecs[0] = '{a: 32'd40,         b: 32'd40, q: 32'd1,         r: 32'd0,   lat: 33};
    vecs[1] = '{a: 32'd40,         b: 32'd20, q: 32'd2,         r: 32'd0,   lat: 33};
    vecs[2] = '{a: 32'd20,         b: 32'd40, q: 32'd0,         r: 32'd20,  lat: 33};
    vecs[3] = '{a: 32'd20,         b: 32'd20, q: 32'd1,         r: 32'd0,   lat: 33};
    vecs[4] = '{a: 32'hFFFF_FFFF,  b: 32'd1,  q: 32'hFFFF_FFFF, r: 32'd0,   lat: 33};
    vecs[5] = '{a: 32'd100,        b: 32'd7,  q: 32'd14,        r: 32'd2,   lat: 33};
    vecs[6] = '{a: 32'hFFFF_FFFF,  b: 32'h8000_0001, q: 32'd1,  r: 32'h7FFF_FFFE, lat: 33};
    vecs[7] = '{a: 32'd123,        b: 32'd0,  q: 32'hFFFF_FFFF, r: 32'd123, lat: 1};

    dif.start = 1'b0;
    dif.a     = '0;
    dif.b     = '0;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_valid", {31'd0, dif.div_valid}, 32'd0);
    check("reset_quotient", dif.quotient, 32'd0);
    check("reset_remain", dif.remain, 32'd0);
    rst = 1'b0;

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, q, r, lat);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_q", i), q, vecs[i].q);
      check($sformatf("vec%0d_r", i), r, vecs[i].r);
    end

    // We are in the DONE cycle of 123/0: a start now must be ignored.
    dif.a     = 32'd5;
    dif.b     = 32'd1;
    dif.start = 1'b1;
    @(negedge clk);
    dif.start = 1'b0;
    watch_valid(40, seen);
    check("done_start_ignored", {31'd0, seen}, 32'd0);
    check("done_start_q_held", dif.quotient, 32'hFFFF_FFFF);
    check("done_start_r_held", dif.remain, 32'd123);

    // Start while BUSY is ignored: 40/20 with a 9/3 request mid-flight.
    @(negedge clk);
    dif.a     = 32'd40;
    dif.b     = 32'd20;
    dif.start = 1'b1;
    @(negedge clk);
    dif.start = 1'b0;
    lat = 1;
    while (dif.div_valid !== 1'b1 && lat < TIMEOUT) begin
      if (lat == 10) begin
        dif.a     = 32'd9;
        dif.b     = 32'd3;
        dif.start = 1'b1;
      end else begin
        dif.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    dif.start = 1'b0;
    check("busy_start_lat", 32'(lat), 32'd33);
    check("busy_start_q", dif.quotient, 32'd2);
    check("busy_start_r", dif.remain, 32'd0);
    watch_valid(40, seen);
    check("busy_start_no_extra", {31'd0, seen}, 32'd0);

    // Reset at iteration 10 of a later operation: no pulse, outputs cleared.
    @(negedge clk);
    dif.a     = 32'd1000;
    dif.b     = 32'd3;
    dif.start = 1'b1;
    @(negedge clk);
    dif.start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midreset_valid", {31'd0, dif.div_valid}, 32'd0);
    check("midreset_quotient", dif.quotient, 32'd0);
    check("midreset_remain", dif.remain, 32'd0);
    watch_valid(40, seen);
    check("midreset_no_pulse", {31'd0, seen}, 32'd0);
    do_check("post_reset", 32'd100, 32'd7);

    // Random operands against the model; small divisors and zero mixed in.
    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom;
        1:       b = $urandom_range(1, 255);
        2:       b = a >> $urandom_range(0, 31);
        default: b = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'd1;
      endcase
      do_check($sformatf("rand%0d", i), a, b);
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_divider

// File: doc/divider.md
Name: divider

Overview:
- Multi-cycle unsigned 32-bit integer divider producing quotient and remainder. It serves as the RV32M DIVU/REMU execution unit.
- It uses a start/valid handshake.
- It is iterative (radix-2 restoring), one quotient bit per clock.

Parameters:
- WIDTH, 32, operand/result width; must equal rv32i_word width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; operands sampled on the same edge.
- a  input  32 (rv32i_word)  dividend, unsigned.
- b  input  32 (rv32i_word)  divisor, unsigned.
- quotient  output  32 (rv32i_word)  a / b.
- remain  output  32 (rv32i_word)  a mod b.
- div_valid  output  1  one-cycle pulse: quotient/remain valid.

Behaviour:
- Reset (rst=1 at rising edge):
  - state=IDLE.
  - quotient=0, remain=0, div_valid=0.
  - All internal registers cleared.
  - Reset mid-operation aborts with no div_valid pulse.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If start=1 at edge N, latch a and b.
  - If b!=0: remainder accumulator=0, quotient shift register=a, bit count=0, go to BUSY.
  - If b==0: go to DONE directly.
- BUSY, one iteration per edge:
  - Shift {rem,quo} left 1.
  - trial = rem_shifted - b, computed as 33-bit.
  - If trial non-negative: rem=trial and quo LSB=1. Otherwise quo LSB=0.
  - After 32nd iteration (edge N+32), go to DONE.
- DONE:
  - div_valid=1 for exactly one cycle. For b!=0 this is the cycle after edge N+32; for b==0 it is the cycle after edge N.
  - Next edge returns to IDLE.
- quotient/remain registered; updated on entry to DONE and held stable until the next result, including while IDLE/BUSY.
- Divide by zero: quotient=32'hFFFF_FFFF, remain=a (RISC-V semantics).
- start while BUSY or DONE is ignored. Operands are not re-sampled. The caller must hold off until div_valid.
- start in the same cycle the unit is in DONE is ignored; it is accepted only from IDLE.
- a and b may change after the start edge without affecting the result.
- Unsigned only; no overflow case. 32'hFFFF_FFFF / 1 = 32'hFFFF_FFFF, r 0.
- Results computed exactly: quotient*b + remain == a, with remain < b for b!=0.

Decomposition:
- rv32i_types package: supplies rv32i_word (logic [31:0]). Holds the state enum type (div_state_t: IDLE/BUSY/DONE) if shared; otherwise local typedef.
- No sub-module required. An optional combinational div_step (one restoring iteration: rem, quo, divisor in; rem, quo out) is a natural split.
- Iteration counter: 5–6 bits local.

Test Plan:
- a=40, b=40, start 1 cycle -> div_valid pulse after 32 iteration cycles; quotient=1, remain=0.
- a=40, b=20 -> quotient=2, remain=0.
- a=20, b=40 -> quotient=0, remain=20; a=20, b=20 -> quotient=1, remain=0.
- a=32'hFFFF_FFFF, b=1 -> quotient=32'hFFFF_FFFF, remain=0. a=100, b=7 -> quotient=14, remain=2.
- a=123, b=0 -> div_valid one cycle after start edge; quotient=32'hFFFF_FFFF, remain=123.
- Start a=40, b=20; pulse start again mid-BUSY with a=9, b=3; assert rst at iteration 10 of a later operation:
  - Second start is ignored; result is 2 r 0.
  - After reset: no div_valid, outputs 0, new start then works normally.
  - div_valid never stays high for more than 1 cycle.
